// File: rtl/load_buffer.sv
// Load buffer: tracks in-flight loads from dispatch through address capture,
// store-conflict clearance, a single outstanding datactrl read and write-back.
module load_buffer #(
  parameter int LBWidth      = 3,
  parameter int ROBWidth     = 4,
  parameter int AddressWidth = 32,
  parameter int IDWidth      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    rob_rst_in,
  input  logic                    dispatcher_lbuffer_en_in,
  input  logic [2:0]              dispatcher_lbuffer_funct3_in,
  input  logic [ROBWidth-1:0]     dispatcher_lbuffer_h_in,
  output logic                    lbuffer_dispatcher_full_out,
  input  logic [ROBWidth-1:0]     addrunit_lbuffer_h_in,
  input  logic [AddressWidth-1:0] addrunit_lbuffer_address_in,
  output logic                    lbuffer_rob_en_out,
  output logic [ROBWidth-1:0]     lbuffer_rob_rob_index_out,
  output logic [LBWidth-1:0]      lbuffer_rob_lbuffer_index_out,
  input  logic [LBWidth-1:0]      rob_lbuffer_index_in,
  output logic                    lbuffer_datactrl_en_out,
  output logic [AddressWidth-1:0] lbuffer_datactrl_addr_out,
  output logic [2:0]              lbuffer_datactrl_width_out,
  input  logic                    datactrl_lbuffer_en_in,
  input  logic [IDWidth-1:0]      datactrl_lbuffer_data_in,
  output logic [ROBWidth-1:0]     lbuffer_rob_h_out,
  output logic [IDWidth-1:0]      lbuffer_rob_value_out
);
  localparam int NE = 1 << LBWidth;

  typedef enum logic [2:0] {
    E_FREE, E_NOADDR, E_ADDR, E_WAIT, E_READY, E_ISSUED
  } entry_e;
  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_e;

  entry_e                  state_q [NE];
  entry_e                  state_d [NE];
  logic [2:0]              funct3_q [NE];
  logic [2:0]              funct3_d [NE];
  logic [ROBWidth-1:0]     tag_q [NE];
  logic [ROBWidth-1:0]     tag_d [NE];
  logic [AddressWidth-1:0] addr_q [NE];
  logic [AddressWidth-1:0] addr_d [NE];

  mem_e                    mem_q, mem_d;
  logic [LBWidth-1:0]      cur_q, cur_d;
  logic                    drop_q, drop_d;

  logic                    rep_en_q, rep_en_d;
  logic [ROBWidth-1:0]     rep_tag_q, rep_tag_d;
  logic [LBWidth-1:0]      rep_idx_q, rep_idx_d;
  logic                    dc_en_q, dc_en_d;
  logic [AddressWidth-1:0] dc_addr_q, dc_addr_d;
  logic [2:0]              dc_width_q, dc_width_d;
  logic [ROBWidth-1:0]     wb_h_q, wb_h_d;
  logic [IDWidth-1:0]      wb_val_q, wb_val_d;

  logic                    free_found, addr_found, ready_found;
  logic [LBWidth-1:0]      free_idx, addr_idx, ready_idx;

  function automatic logic [IDWidth-1:0] extend(input logic [2:0] f3,
                                                input logic [IDWidth-1:0] raw);
    logic [IDWidth-1:0] r;
    case (f3[1:0])
      2'b00:   r = {{(IDWidth-8){~f3[2] & raw[7]}}, raw[7:0]};
      2'b01:   r = {{(IDWidth-16){~f3[2] & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] size_onehot(input logic [1:0] size);
    case (size)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Entry 0 is the "none" index and is never allocated; scanning downwards
  // leaves the lowest matching index in each *_idx.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    addr_found  = 1'b0;
    addr_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = NE - 1; i >= 1; i--) begin
      if (state_q[i] == E_FREE)  begin free_found  = 1'b1; free_idx  = LBWidth'(i); end
      if (state_q[i] == E_ADDR)  begin addr_found  = 1'b1; addr_idx  = LBWidth'(i); end
      if (state_q[i] == E_READY) begin ready_found = 1'b1; ready_idx = LBWidth'(i); end
    end
  end

  assign lbuffer_dispatcher_full_out = ~free_found;

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    mem_d      = mem_q;
    cur_d      = cur_q;
    drop_d     = drop_q;
    rep_en_d   = rep_en_q;
    rep_tag_d  = rep_tag_q;
    rep_idx_d  = rep_idx_q;
    dc_en_d    = dc_en_q;
    dc_addr_d  = dc_addr_q;
    dc_width_d = dc_width_q;
    wb_h_d     = wb_h_q;
    wb_val_d   = wb_val_q;
    if (rdy_in) begin
      rep_en_d = 1'b0;
      dc_en_d  = 1'b0;
      wb_h_d   = '0;
      if (rob_rst_in) begin
        for (int i = 1; i < NE; i++)
          if (state_q[i] != E_ISSUED) state_d[i] = E_FREE;
        // A return landing in the flush cycle retires the read on the spot.
        if (mem_q == MEM_BUSY) begin
          if (datactrl_lbuffer_en_in) begin
            state_d[cur_q] = E_FREE;
            mem_d          = MEM_IDLE;
            drop_d         = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
      end else begin
        if (dispatcher_lbuffer_en_in && free_found) begin
          state_d[free_idx]  = E_NOADDR;
          funct3_d[free_idx] = dispatcher_lbuffer_funct3_in;
          tag_d[free_idx]    = dispatcher_lbuffer_h_in;
        end
        if (addrunit_lbuffer_h_in != '0) begin
          for (int i = 1; i < NE; i++) begin
            if (state_q[i] == E_NOADDR && tag_q[i] == addrunit_lbuffer_h_in) begin
              state_d[i] = E_ADDR;
              addr_d[i]  = addrunit_lbuffer_address_in;
            end
          end
        end
        if (addr_found) begin
          state_d[addr_idx] = E_WAIT;
          rep_en_d          = 1'b1;
          rep_tag_d         = tag_q[addr_idx];
          rep_idx_d         = addr_idx;
        end
        if (rob_lbuffer_index_in != '0 && state_q[rob_lbuffer_index_in] == E_WAIT)
          state_d[rob_lbuffer_index_in] = E_READY;
        case (mem_q)
          MEM_IDLE: begin
            if (ready_found) begin
              state_d[ready_idx] = E_ISSUED;
              dc_en_d            = 1'b1;
              dc_addr_d          = addr_q[ready_idx];
              dc_width_d         = size_onehot(funct3_q[ready_idx][1:0]);
              cur_d              = ready_idx;
              mem_d              = MEM_BUSY;
            end
          end
          default: begin
            if (datactrl_lbuffer_en_in) begin
              state_d[cur_q] = E_FREE;
              mem_d          = MEM_IDLE;
              drop_d         = 1'b0;
              if (!drop_q) begin
                wb_h_d   = tag_q[cur_q];
                wb_val_d = extend(funct3_q[cur_q], datactrl_lbuffer_data_in);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= '{default: E_FREE};
      funct3_q   <= '{default: '0};
      tag_q      <= '{default: '0};
      addr_q     <= '{default: '0};
      mem_q      <= MEM_IDLE;
      cur_q      <= '0;
      drop_q     <= 1'b0;
      rep_en_q   <= 1'b0;
      rep_tag_q  <= '0;
      rep_idx_q  <= '0;
      dc_en_q    <= 1'b0;
      dc_addr_q  <= '0;
      dc_width_q <= '0;
      wb_h_q     <= '0;
      wb_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      mem_q      <= mem_d;
      cur_q      <= cur_d;
      drop_q     <= drop_d;
      rep_en_q   <= rep_en_d;
      rep_tag_q  <= rep_tag_d;
      rep_idx_q  <= rep_idx_d;
      dc_en_q    <= dc_en_d;
      dc_addr_q  <= dc_addr_d;
      dc_width_q <= dc_width_d;
      wb_h_q     <= wb_h_d;
      wb_val_q   <= wb_val_d;
    end
  end

  // Pulses are single-cycle registered strobes with no back-pressure; a
  // frozen cycle (rdy_in low) masks them and holds them for the next live cycle.
  assign lbuffer_rob_en_out            = rep_en_q & rdy_in;
  assign lbuffer_rob_rob_index_out     = rep_tag_q;
  assign lbuffer_rob_lbuffer_index_out = rep_idx_q;
  assign lbuffer_datactrl_en_out       = dc_en_q & rdy_in;
  assign lbuffer_datactrl_addr_out     = dc_addr_q;
  assign lbuffer_datactrl_width_out    = dc_width_q;
  assign lbuffer_rob_h_out             = rdy_in ? wb_h_q : '0;
  assign lbuffer_rob_value_out         = wb_val_q;
endmodule
